// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, source count,
// reset values and the lowest-index-first priority encoder.
package irq_ctrl_defs;

   localparam int               N_SRC    = 6;
   localparam logic [2:0]       ID_NONE  = 3'h7;
   localparam logic [1:0]       IRQ_MASK = 2'd0;
   localparam logic [1:0]       IRQ_MODE = 2'd1;
   localparam logic [1:0]       IRQ_PEND = 2'd2;
   localparam logic [1:0]       IRQ_ID   = 2'd3;
   localparam logic [N_SRC-1:0] MODE_RST = 6'h3F;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } irq_id_t;

   // Walk from the top down so the lowest active index is the last one written.
   function automatic irq_id_t prio_enc(input logic [N_SRC-1:0] act);
      irq_id_t r;
      r.valid = 1'b0;
      r.idx   = ID_NONE;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (act[i]) begin
            r.valid = 1'b1;
            r.idx   = 3'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Bridge Pr bus as seen by the interrupt controller.
// Access semantics: a transfer happens on every rising clk edge where dev_sel=1; pr_we selects
// write (pr_wd captured at that edge) or read (pr_rd valid combinationally in the same cycle).
// There is no wait state and no back-pressure, so no valid/ready pair exists on this bus.
interface irq_ctrl_if;
   logic        dev_sel;
   logic        pr_we;
   logic [1:0]  pr_addr;
   logic [31:0] pr_wd;
   logic [31:0] pr_rd;

   modport master (output dev_sel, pr_we, pr_addr, pr_wd, input pr_rd);
   modport slave  (input dev_sel, pr_we, pr_addr, pr_wd, output pr_rd);
endinterface

// File: rtl/irq_src_cell.sv
// One interrupt source: optional 2-flop synchronizer (IRQ_CTRL_SYNC_EN), edge detector,
// pending bit and sticky overflow bit.
module irq_src_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic src,
   input  logic mode,
   input  logic clear_pend,
   input  logic clear_ovf,
   output logic pend,
   output logic ovf
);

   logic src_s;
   logic src_q;
   logic rise;

`ifdef IRQ_CTRL_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], src};
   end

   assign src_s = sync_q[1];
`else
   assign src_s = src;
`endif

   // src_q resets low, so a source already high at reset release is seen as an edge.
   assign rise = src_s & ~src_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q <= 1'b0;
         pend  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         src_q <= src_s;
         if (mode) begin
            if (rise)            pend <= 1'b1;
            else if (clear_pend) pend <= 1'b0;
         end else begin
            pend <= src_s;
         end
         // A repeat edge only counts as overflow when it is not racing an acknowledge.
         if (mode && rise && pend && !clear_pend) ovf <= 1'b1;
         else if (clear_ovf)                      ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: MASK/MODE registers, PEND/ID read-back, registered hwint.
// Build option IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer per source (+2 cycles latency).
module irq_ctrl
   import irq_ctrl_defs::*;
(
   input  logic             clk,
   input  logic             sys_rstn,
   input  logic [N_SRC-1:0] irq_src,
   irq_ctrl_if.slave        bus,
   output logic [N_SRC-1:0] hwint
);

   logic [N_SRC-1:0] mask_q;
   logic [N_SRC-1:0] mode_q;
   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] ovf;
   logic [N_SRC-1:0] clr_pend;
   logic [N_SRC-1:0] clr_ovf;
   logic             wr_en;
   irq_id_t          id;
   logic             unused_wd;

   assign wr_en     = bus.dev_sel & bus.pr_we;
   assign clr_pend  = (wr_en && bus.pr_addr == IRQ_PEND) ? bus.pr_wd[5:0]  : '0;
   assign clr_ovf   = (wr_en && bus.pr_addr == IRQ_PEND) ? bus.pr_wd[13:8] : '0;
   assign unused_wd = ^{bus.pr_wd[31:14], bus.pr_wd[7:6]};

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      irq_src_cell u_cell (
         .clk        (clk),
         .rst_n      (sys_rstn),
         .src        (irq_src[i]),
         .mode       (mode_q[i]),
         .clear_pend (clr_pend[i]),
         .clear_ovf  (clr_ovf[i]),
         .pend       (pend[i]),
         .ovf        (ovf[i])
      );
   end

   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         mask_q <= '0;
         mode_q <= MODE_RST;
         hwint  <= '0;
      end else begin
         if (wr_en && bus.pr_addr == IRQ_MASK) mask_q <= bus.pr_wd[5:0];
         if (wr_en && bus.pr_addr == IRQ_MODE) mode_q <= bus.pr_wd[5:0];
         hwint <= pend & mask_q;
      end
   end

   assign id = prio_enc(pend & mask_q);

   always_comb begin
      bus.pr_rd = '0;
      if (bus.dev_sel) begin
         case (bus.pr_addr)
            IRQ_MASK: bus.pr_rd = {26'b0, mask_q};
            IRQ_MODE: bus.pr_rd = {26'b0, mode_q};
            IRQ_PEND: bus.pr_rd = {16'b0, 2'b0, ovf, 2'b0, pend};
            default:  bus.pr_rd = {id.valid, 28'b0, id.idx};
         endcase
      end
   end

endmodule
